// File: rtl/dff_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ register writers and the shared-register arbiter.
//   req_valid/req_lock/req_data : per-requester write request, lock intent and data
//   req_ready                   : one-hot grant back to the requesters (combinational)
//   q/q_owner/upd               : shared register, last accepted writer, update pulse
//   locked/lock_timeout         : lock state and forced-release pulse
// master = requester side, slave = arbiter side.
interface dff_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         q;
  logic [IDX_W-1:0]              q_owner;
  logic                          upd;
  logic                          locked;
  logic                          lock_timeout;

  modport master (
    output req_valid, req_lock, req_data,
    input  req_ready, q, q_owner, upd, locked, lock_timeout
  );

  modport slave (
    input  req_valid, req_lock, req_data,
    output req_ready, q, q_owner, upd, locked, lock_timeout
  );
endinterface

// File: rtl/dff_wr_arbiter.sv
// Round-robin arbiter sharing one DATA_WIDTH register among NUM_REQ writers,
// with an optional bounded bus lock for burst ownership.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dff_wr_arbiter_if.slave (requests in; grant, register and status out)
module dff_wr_arbiter #(
  parameter int unsigned           NUM_REQ     = 4,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           LOCK_MAX    = 16
) (
  input logic             clock,
  input logic             reset,
  dff_wr_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned      CNT_W    = $clog2(LOCK_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state, state_nx;
  logic [IDX_W-1:0]      ptr, ptr_nx;
  logic [CNT_W-1:0]      lock_cnt, lock_cnt_nx;
  logic [DATA_WIDTH-1:0] q_nx;
  logic [IDX_W-1:0]      owner_nx;
  logic                  upd_nx;
  logic                  timeout_nx;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      cand;
  logic                  gnt_any;
  logic                  gnt_lock;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  // Grant selection. While locked the owner is q_owner: only the owner can be
  // accepted in LOCKED, so the last accepted writer is always the lock owner.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (state == LOCKED) begin
      gnt_idx = bus.q_owner;
      gnt_any = bus.req_valid[bus.q_owner];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
        if (!gnt_any && bus.req_valid[cand]) begin
          gnt_idx = cand;
          gnt_any = 1'b1;
        end
      end
    end
    if (reset) gnt_any = 1'b0;
  end

  assign gnt_lock = bus.req_lock[gnt_idx];

  // One-hot ready toward the requesters
  always_comb begin
    bus.req_ready = '0;
    if (gnt_any) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    lock_cnt_nx = lock_cnt;
    q_nx        = bus.q;
    owner_nx    = bus.q_owner;
    upd_nx      = 1'b0;
    timeout_nx  = 1'b0;

    if (gnt_any) begin
      q_nx     = bus.req_data[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
      owner_nx = gnt_idx;
      upd_nx   = 1'b1;
    end

    case (state)
      IDLE: begin
        if (gnt_any) begin
          if (gnt_lock) begin
            state_nx    = LOCKED;
            lock_cnt_nx = '0;
          end else begin
            ptr_nx = next_idx(gnt_idx);
          end
        end
      end
      LOCKED: begin
        lock_cnt_nx = lock_cnt + CNT_W'(1);
        // A normal release wins over a coinciding timeout
        if (gnt_any && !gnt_lock) begin
          state_nx    = IDLE;
          ptr_nx      = next_idx(bus.q_owner);
          lock_cnt_nx = '0;
        end else if (lock_cnt == CNT_LAST) begin
          state_nx    = IDLE;
          ptr_nx      = next_idx(bus.q_owner);
          lock_cnt_nx = '0;
          timeout_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      lock_cnt         <= '0;
      bus.q            <= RESET_VALUE;
      bus.q_owner      <= '0;
      bus.upd          <= 1'b0;
      bus.lock_timeout <= 1'b0;
    end else begin
      state            <= state_nx;
      ptr              <= ptr_nx;
      lock_cnt         <= lock_cnt_nx;
      bus.q            <= q_nx;
      bus.q_owner      <= owner_nx;
      bus.upd          <= upd_nx;
      bus.lock_timeout <= timeout_nx;
    end
  end

  assign bus.locked = (state == LOCKED);

endmodule
